mdio_master: RTL and testbench

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_pkg.sv | 23 ++
 rtl/mdio_master.sv | 157 +++++++++++++++
 tb/tb_mdio_master.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// MDIO master shared state encoding and frame field constants.
// Imported by mdio_master.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        TA,
        DATA
    } state_e;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    // Last bit index inside each fixed-length frame section.
    localparam logic [4:0] HDR_LAST  = 5'd13;
    localparam logic [4:0] TA_LAST   = 5'd1;
    localparam logic [4:0] DATA_LAST = 5'd15;

endpackage

// File: rtl/mdio_master.sv
// MDIO (clause 22) management master: one frame per request, 2 clocks per bit.
// Optional macro MDIO_TA_CHECK_EN enables the read turnaround fault flag.
module mdio_master
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR      = 5'd0,
    parameter int         PREAMBLE_BITS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  addr,
    input  logic [15:0] wr_data,
    input  logic        rd_request,
    input  logic        wr_request,
    output logic        ready,
    output logic [15:0] rd_data,
    output logic        rd_error,
    inout  wire         mdio_pin,
    output logic        mdc_pin
);

    localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_BITS - 1);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic [31:0] sh_q, sh_d;
    logic        rd_q, rd_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        drv_en, drv_bit;
    logic [4:0]  last_v;
    state_e      next_v;
`ifdef MDIO_TA_CHECK_EN
    logic        ta_q, ta_d;
    logic        rd_error_q, rd_error_d;
`endif

    // Frame sequencer: section/bit counting, serial shift and read capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        sh_d      = sh_q;
        rd_d      = rd_q;
        rd_data_d = rd_data_q;
        drv_en    = 1'b0;
        drv_bit   = 1'b0;
        last_v    = '0;
        next_v    = IDLE;
`ifdef MDIO_TA_CHECK_EN
        ta_d       = ta_q;
        rd_error_d = rd_error_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (wr_request || rd_request) begin
                    state_d = PREAMBLE;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    rd_d    = !wr_request;
                    sh_d    = {ST_CODE,
                               wr_request ? OP_WRITE : OP_READ,
                               PHY_ADDR, addr, TA_WRITE, wr_data};
                end
            end
            PREAMBLE: begin
                drv_en  = 1'b1;
                drv_bit = 1'b1;
                last_v  = PRE_LAST;
                next_v  = HEADER;
            end
            HEADER: begin
                drv_en  = 1'b1;
                drv_bit = sh_q[31];
                last_v  = HDR_LAST;
                next_v  = TA;
            end
            TA: begin
                drv_en  = !rd_q;
                drv_bit = sh_q[31];
                last_v  = TA_LAST;
                next_v  = DATA;
            end
            DATA: begin
                drv_en  = !rd_q;
                drv_bit = sh_q[31];
                last_v  = DATA_LAST;
                next_v  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Second clock of a bit closes it: sample the line, shift, advance.
        if (state_q != IDLE) begin
            phase_d = !phase_q;
            if (phase_q) begin
                cnt_d = cnt_q + 5'd1;
                if (state_q != PREAMBLE) begin
                    sh_d = {sh_q[30:0], mdio_pin};
                end
                if (cnt_q == last_v) begin
                    cnt_d   = '0;
                    state_d = next_v;
                end
`ifdef MDIO_TA_CHECK_EN
                if (state_q == TA && cnt_q == TA_LAST && rd_q) begin
                    ta_d = mdio_pin;
                end
`endif
                if (state_q == DATA && cnt_q == DATA_LAST && rd_q) begin
                    rd_data_d = {sh_q[14:0], mdio_pin};
`ifdef MDIO_TA_CHECK_EN
                    rd_error_d = ta_q;
`endif
                end
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            sh_q      <= '0;
            rd_q      <= 1'b0;
            rd_data_q <= '0;
`ifdef MDIO_TA_CHECK_EN
            ta_q       <= 1'b0;
            rd_error_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            sh_q      <= sh_d;
            rd_q      <= rd_d;
            rd_data_q <= rd_data_d;
`ifdef MDIO_TA_CHECK_EN
            ta_q       <= ta_d;
            rd_error_q <= rd_error_d;
`endif
        end
    end

    assign ready    = (state_q == IDLE);
    assign mdc_pin  = phase_q;
    assign rd_data  = rd_data_q;
    assign mdio_pin = drv_en ? drv_bit : 1'bz;
`ifdef MDIO_TA_CHECK_EN
    assign rd_error = rd_error_q;
`else
    assign rd_error = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master with a PHY model and a switchable pull-up.
`timescale 1ns/1ps
module tb_mdio_master;

    localparam int         P   = 32;
    localparam int         FB  = P + 32;
    localparam logic [4:0] PHY = 5'd19;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic [4:0]  addr       = '0;
    logic [15:0] wr_data    = '0;
    logic        rd_request = 1'b0;
    logic        wr_request = 1'b0;
    logic        ready, rd_error, mdc_pin;
    logic [15:0] rd_data;
    wire         mdio;

    logic        phy_en   = 1'b0;
    logic        pull_en  = 1'b0;
    logic        phy_drv  = 1'b0;
    logic        phy_bit  = 1'b0;
    logic [15:0] phy_data = '0;
    logic        tb_oe, tb_val;

    assign tb_oe  = (phy_drv & ~ready) | pull_en;
    assign tb_val = (phy_drv & ~ready) ? phy_bit : 1'b1;
    assign mdio   = tb_oe ? tb_val : 1'bz;

    always #5 clock = ~clock;

    mdio_master #(
        .PHY_ADDR      (PHY),
        .PREAMBLE_BITS (P)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_request (rd_request),
        .wr_request (wr_request),
        .ready      (ready),
        .rd_data    (rd_data),
        .rd_error   (rd_error),
        .mdio_pin   (mdio),
        .mdc_pin    (mdc_pin)
    );

    typedef struct {
        bit          is_rd;
        bit          phy;
        logic [4:0]  a;
        logic [15:0] d;
        logic [15:0] exp_rd;
        logic        exp_err;
        bit          aborted;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_rd   = '0;
    logic        m_err  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Frame as the line should carry it, first bit in the MSB.
    function automatic logic [FB-1:0] frame_of(input bit is_rd,
                                               input logic [4:0] a,
                                               input logic [15:0] d);
        return {{P{1'b1}}, 2'b01, (is_rd ? 2'b10 : 2'b01), PHY, a,
                (is_rd ? 2'b00 : 2'b10), (is_rd ? 16'h0000 : d)};
    endfunction

    int            cyc      = 0;
    int            nb       = 0;
    logic [FB-1:0] got      = '0;
    logic          prev_rdy = 1'b1;

    task automatic finish_frame();
        exp_t          e;
        logic [FB-1:0] ef;
        if (expq.size() == 0) begin
            chk("unexpected_frame", 64'(cyc), 64'd0);
            return;
        end
        e = expq.pop_front();
        if (e.aborted) begin
            chk("abort_rd_data", rd_data, 0);
            chk("abort_rd_error", rd_error, 0);
            return;
        end
        chk("latency", 64'(cyc), 64'(2 * FB));
        chk("rd_data", rd_data, e.exp_rd);
        chk("rd_error", rd_error, e.exp_err);
        ef = frame_of(e.is_rd, e.a, e.d);
        if (!e.is_rd) begin
            chk("wr_frame", got, ef);
            chk("wr_bits", 64'(nb), 64'(FB));
        end else if (e.phy) begin
            chk("rd_header", got[FB-1:18], ef[FB-1:18]);
            chk("rd_ta1_released", 64'(got[17] === 1'b1), 0);
            chk("rd_ta2", got[16], 0);
            chk("rd_line_data", got[15:0], e.d);
        end
    endtask

    // Monitor: decode line bits on MDC high, run the PHY, score at ready rise.
    always @(negedge clock) begin : mon
        int k;
        int idx;
        if (ready === 1'b0) begin
            cyc = cyc + 1;
            if (mdc_pin === 1'b1) begin
                got = {got[FB-2:0], mdio};
                nb  = nb + 1;
            end
            k   = (cyc - 1) / 2;
            idx = 31 + P - k;
            phy_drv <= phy_en && (k >= P + 15) && (k < P + 32);
            if (idx >= 0 && idx <= 15) phy_bit <= phy_data[idx];
            else                       phy_bit <= 1'b0;
        end else if (ready === 1'b1) begin
            if (!prev_rdy) finish_frame();
            cyc = 0;
            nb  = 0;
            got = '0;
            phy_drv <= 1'b0;
        end
        prev_rdy = ready;
    end

    task automatic issue(input bit wr, input bit rd, input bit phy,
                         input logic [4:0] a, input logic [15:0] d,
                         input logic [15:0] pd);
        exp_t e;
        int   n = 0;
        while (ready !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("ready_before_issue", ready, 1);
        e.is_rd   = !wr;
        e.phy     = phy;
        e.a       = a;
        e.d       = wr ? d : pd;
        e.aborted = 1'b0;
        if (!wr) begin
            m_rd = phy ? pd : 16'hFFFF;
`ifdef MDIO_TA_CHECK_EN
            m_err = !phy;
`else
            m_err = 1'b0;
`endif
        end
        e.exp_rd  = m_rd;
        e.exp_err = m_err;
        expq.push_back(e);
        phy_en     = !wr && phy;
        phy_data   = pd;
        pull_en    = !wr && !phy;
        addr       = a;
        wr_data    = d;
        wr_request = wr;
        rd_request = rd;
        @(negedge clock);
        wr_request = 1'b0;
        rd_request = 1'b0;
        addr       = 5'($urandom);
        wr_data    = 16'($urandom);
        chk("accepted", ready, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (ready !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("frame_done", ready, 1);
        repeat (2) @(negedge clock);
        phy_en  = 1'b0;
        pull_en = 1'b0;
    endtask

    initial begin
        exp_t ab;
        int   kind;
        int   busy;
        repeat (3) @(negedge clock);
        chk("rst_ready", ready, 1);
        chk("rst_mdc", mdc_pin, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_error", rd_error, 0);
        chk("rst_mdio_released", 64'(mdio === 1'b1), 0);
        reset = 1'b0;
        @(negedge clock);

        issue(1'b1, 1'b0, 1'b0, 5'd9, 16'h0200, 16'h0000);
        wait_done();
        issue(1'b0, 1'b1, 1'b1, 5'd1, 16'h0000, 16'h796D);
        wait_done();
        issue(1'b0, 1'b1, 1'b0, 5'd4, 16'h0000, 16'h0000);
        wait_done();
        issue(1'b1, 1'b0, 1'b0, 5'd30, 16'hA5C3, 16'h0000);
        wait_done();

        for (int i = 0; i < 10; i++) begin
            kind = int'($urandom_range(0, 2));
            issue(kind == 0, kind != 0, kind == 1, 5'($urandom),
                  16'($urandom), 16'($urandom));
            wait_done();
        end

        issue(1'b1, 1'b1, 1'b0, 5'd17, 16'h1234, 16'h0000);
        repeat (40) @(negedge clock);
        rd_request = 1'b1;
        @(negedge clock);
        rd_request = 1'b0;
        wait_done();
        busy = 0;
        repeat (10) begin
            @(negedge clock);
            if (ready !== 1'b1) busy++;
        end
        chk("no_second_frame", 64'(busy), 0);

        issue(1'b0, 1'b1, 1'b1, 5'd2, 16'h0000, 16'hBEEF);
        repeat (104) @(negedge clock);
        ab = expq.pop_front();
        ab.aborted = 1'b1;
        expq.push_front(ab);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_mdc", mdc_pin, 0);
        chk("midrst_mdio_released", 64'(mdio === 1'b1), 0);
        chk("midrst_rd_data", rd_data, 0);
        chk("midrst_rd_error", rd_error, 0);
        m_rd  = '0;
        m_err = 1'b0;
        @(negedge clock);
        reset  = 1'b0;
        phy_en = 1'b0;
        @(negedge clock);
        issue(1'b1, 1'b0, 1'b0, 5'd9, 16'h8001, 16'h0000);
        wait_done();

        chk("queue_empty", 64'(expq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
